// File: rtl/de2_115_pio_in_debounced.sv
// rtl/de2_115_pio_in_debounced.sv - Avalon-MM input PIO with per-channel sync, debounce and edge capture
// Maskable level interrupt from captured edges; registered read path.
module de2_115_pio_in_debounced #(
    parameter int          WIDTH           = 4,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          EDGE_TYPE       = 1,
    parameter logic [31:0] IRQ_MASK_RESET  = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CW      = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int DB_LAST = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_LAST);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_w;
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_dly_q;
    logic [WIDTH-1:0] edge_w;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] clr_w;
    logic [31:0]      rd_q, rd_d;
    logic             wr_en;

    wire unused_wd = ^writedata;

    assign sync_w = sync_q[SYNC_STAGES-1];
    assign wr_en  = chipselect & ~write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // A mismatch must persist for DEBOUNCE_CYCLES consecutive edges before it is accepted.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) cnt_d[i] = cnt_q[i];
        if (DEBOUNCE_CYCLES == 0) begin
            stable_d = sync_w;
            for (int i = 0; i < WIDTH; i++) cnt_d[i] = '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_w[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync_w[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        edge_w = '0;
        case (EDGE_TYPE)
            0:       edge_w = stable_q & ~stable_dly_q;
            1:       edge_w = ~stable_q & stable_dly_q;
            default: edge_w = stable_q ^ stable_dly_q;
        endcase
    end

    // A new edge outranks a simultaneous write-1-to-clear so no event is lost.
    always_comb begin
        mask_d = mask_q;
        clr_w  = '0;
        if (wr_en && address == 2'd2) mask_d = writedata[WIDTH-1:0];
        if (wr_en && address == 2'd3) clr_w = writedata[WIDTH-1:0];
        edge_cap_d = (edge_cap_q & ~clr_w) | edge_w;
    end

    always_comb begin
        rd_d = '0;
        case (address)
            2'd0:    rd_d[WIDTH-1:0] = stable_q;
            2'd2:    rd_d[WIDTH-1:0] = mask_q;
            2'd3:    rd_d[WIDTH-1:0] = edge_cap_q;
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            edge_cap_q   <= '0;
            mask_q       <= IRQ_MASK_RESET[WIDTH-1:0];
            rd_q         <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            edge_cap_q   <= edge_cap_d;
            mask_q       <= mask_d;
            rd_q         <= rd_d;
        end
    end

    assign readdata = rd_q;
    assign irq      = |(edge_cap_q & mask_q);

endmodule
